rom_sram_loader: RTL and testbench

- Boot-time copy engine that reads the on-chip boot ROM and writes its contents into external SRAM.
- Drives the ROM's 14-bit address and consumes its registered 8-bit data output, which has 1-cycle read latency.
- Sequences byte-wide SRAM writes through the SRAM arbiter using a request/grant handshake.
- Holds the CPU off the bus until the image is resident.

---
 rtl/rom_sram_loader.sv | 138 +++++++++++++
 tb/tb_rom_sram_loader.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_sram_loader.sv
// Boot copy engine: streams LENGTH bytes from the boot ROM into external SRAM through the arbiter.
// Define LOADER_CHECKSUM_EN to build the running 16-bit byte-sum on the checksum output.
module rom_sram_loader #(
  parameter logic [13:0] SRC_BASE  = 14'h0200,
  parameter logic [20:0] DST_BASE  = 21'h000000,
  parameter int          LENGTH    = 16384,
  parameter int          SRAM_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [13:0] rom_a,
  input  logic [7:0]  rom_din,
  output logic        sram_req,
  input  logic        sram_grant,
  output logic [20:0] sram_a,
  output logic [7:0]  sram_dout,
  output logic        sram_we_n,
  output logic [15:0] checksum
);

  localparam logic [14:0] LAST_COUNT = 15'(LENGTH - 1);
  localparam logic [2:0]  WAIT_INIT  = 3'(SRAM_WAIT);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LATCH = 3'd2,
    ARB   = 3'd3,
    WRITE = 3'd4,
    HOLD  = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t      state_r;
  logic [13:0] src_r;
  logic [20:0] dst_r;
  logic [14:0] count_r;
  logic [7:0]  data_r;
  logic [2:0]  wait_r;

  // Copy sequencer; every bus-facing output is registered and changes on state entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      src_r     <= SRC_BASE;
      dst_r     <= DST_BASE;
      count_r   <= 15'd0;
      data_r    <= 8'h00;
      wait_r    <= 3'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rom_a     <= SRC_BASE;
      sram_req  <= 1'b0;
      sram_a    <= DST_BASE;
      sram_dout <= 8'h00;
      sram_we_n <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            src_r   <= SRC_BASE;
            dst_r   <= DST_BASE;
            count_r <= 15'd0;
            rom_a   <= SRC_BASE;
            done    <= 1'b0;
            busy    <= 1'b1;
            state_r <= FETCH;
          end else begin
            state_r <= IDLE;
          end
        end
        FETCH: state_r <= LATCH;
        LATCH: begin
          data_r   <= rom_din;
          sram_req <= 1'b1;
          state_r  <= ARB;
        end
        ARB: begin
          if (sram_grant) begin
            wait_r    <= WAIT_INIT;
            sram_a    <= dst_r;
            sram_dout <= data_r;
            sram_we_n <= 1'b0;
            state_r   <= WRITE;
          end else begin
            state_r <= ARB;
          end
        end
        WRITE: begin
          // Grant is deliberately not looked at once the strobe is low.
          if (wait_r == 3'd0) begin
            sram_we_n <= 1'b1;
            state_r   <= HOLD;
          end else begin
            wait_r <= wait_r - 3'd1;
          end
        end
        HOLD: begin
          sram_req <= 1'b0;
          if (count_r == LAST_COUNT) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= DONE;
          end else begin
            src_r   <= src_r + 14'd1;
            dst_r   <= dst_r + 21'd1;
            count_r <= count_r + 15'd1;
            rom_a   <= src_r + 14'd1;
            state_r <= FETCH;
          end
        end
        DONE: state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running byte sum, accumulated from the ROM data as each byte is latched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum <= 16'h0000;
    end else if (state_r == IDLE && start) begin
      checksum <= 16'h0000;
    end else if (state_r == LATCH) begin
      checksum <= checksum + {8'h00, rom_din};
    end else begin
      checksum <= checksum;
    end
  end
`else
  assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_rom_sram_loader.sv
// Bench for rom_sram_loader: three parameterisations run side by side, each checked every
// cycle against a model that tracks only the byte index and the cycle position inside a byte.
module tb_rom_sram_loader;

  localparam int N = 3;
  localparam logic [13:0] SRC [N] = '{14'h0200, 14'h3FFE, 14'h0064};
  localparam logic [20:0] DST [N] = '{21'h000000, 21'h1FFFFE, 21'h1FFFFC};
  localparam int LEN [N] = '{4, 4, 8};
  localparam int WT  [N] = '{1, 0, 7};
  localparam int LAT [N] = '{24, 20, 96};
  localparam int PW  [N] = '{2, 1, 8};

  logic        clk;
  logic        rst_n;
  logic        start     [N];
  logic        grant     [N];
  logic        busy      [N];
  logic        done      [N];
  logic [13:0] rom_a     [N];
  logic [7:0]  rom_din   [N];
  logic        req       [N];
  logic [20:0] sram_a    [N];
  logic [7:0]  sram_dout [N];
  logic        we_n      [N];
  logic [15:0] checksum  [N];
  logic [7:0]  rom       [16384];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  bit          act    [N];
  bit          cool   [N];
  bit          done_m [N];
  int          k      [N];
  int          c      [N];
  logic [13:0] ra_m   [N];
  logic [20:0] sa_m   [N];
  logic [7:0]  sd_m   [N];
  logic [15:0] sum_m  [N];

  int          run        [N];
  int          t0         [N];
  int          lat        [N];
  int          done_rises [N];
  logic        prev_we    [N];
  logic        prev_busy  [N];
  logic        prev_done  [N];
  logic [13:0] prev_ra1;
  bit          rec = 1'b0;
  logic [13:0] seq1 [$];
  logic [28:0] wr0  [$];

  for (genvar g = 0; g < N; g++) begin : g_dut
    rom_sram_loader #(
      .SRC_BASE(SRC[g]), .DST_BASE(DST[g]), .LENGTH(LEN[g]), .SRAM_WAIT(WT[g])
    ) dut (
      .clk(clk), .rst_n(rst_n), .start(start[g]), .busy(busy[g]), .done(done[g]),
      .rom_a(rom_a[g]), .rom_din(rom_din[g]), .sram_req(req[g]), .sram_grant(grant[g]),
      .sram_a(sram_a[g]), .sram_dout(sram_dout[g]), .sram_we_n(we_n[g]), .checksum(checksum[g])
    );

    always @(posedge clk) rom_din[g] <= rom[rom_a[g]];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [13:0] src_at(input int i, input int kk);
    return SRC[i] + 14'(kk);
  endfunction

  function automatic logic [20:0] dst_at(input int i, input int kk);
    return DST[i] + 21'(kk);
  endfunction

  task automatic chk(input string name, input int inst, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] @cycle %0d: got %0h, expected %0h", name, inst, cyc, got, exp);
    end
  endtask

  // Model advance (inputs here are the values sampled at the preceding rising edge) and compare.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < N; i++) begin
        if (!rst_n) begin
          act[i] = 1'b0; cool[i] = 1'b0; done_m[i] = 1'b0; k[i] = 0; c[i] = 0;
          ra_m[i] = SRC[i]; sa_m[i] = DST[i]; sd_m[i] = 8'h00; sum_m[i] = 16'h0000;
          chk("rst_busy", i, busy[i], 1'b0);
          chk("rst_done", i, done[i], 1'b0);
          chk("rst_req", i, req[i], 1'b0);
          chk("rst_we_n", i, we_n[i], 1'b1);
          chk("rst_rom_a", i, rom_a[i], SRC[i]);
          chk("rst_sram_a", i, sram_a[i], DST[i]);
          chk("rst_dout", i, sram_dout[i], 8'h00);
          chk("rst_checksum", i, checksum[i], 16'h0000);
          run[i] = 0; prev_we[i] = 1'b1; prev_busy[i] = 1'b0; prev_done[i] = 1'b0;
        end else begin
          if (cool[i]) begin
            cool[i] = 1'b0;
          end else if (!act[i]) begin
            if (start[i]) begin
              act[i] = 1'b1; k[i] = 0; c[i] = 0; done_m[i] = 1'b0;
              sum_m[i] = 16'h0000; ra_m[i] = SRC[i];
            end
          end else if (c[i] == 2 && !grant[i]) begin
            c[i] = 2;
          end else if (c[i] == WT[i] + 4) begin
            if (k[i] == LEN[i] - 1) begin
              act[i] = 1'b0; cool[i] = 1'b1; done_m[i] = 1'b1;
            end else begin
              k[i]++; c[i] = 0; ra_m[i] = src_at(i, k[i]);
            end
          end else begin
`ifdef LOADER_CHECKSUM_EN
            if (c[i] == 1) sum_m[i] = sum_m[i] + {8'h00, rom[src_at(i, k[i])]};
`endif
            c[i]++;
            if (c[i] == 3) begin
              sa_m[i] = dst_at(i, k[i]);
              sd_m[i] = rom[src_at(i, k[i])];
            end
          end

          chk("busy", i, busy[i], act[i]);
          chk("done", i, done[i], done_m[i]);
          chk("sram_req", i, req[i], (act[i] && c[i] >= 2));
          chk("sram_we_n", i, we_n[i], !(act[i] && c[i] >= 3 && c[i] <= 3 + WT[i]));
          chk("rom_a", i, rom_a[i], ra_m[i]);
          chk("sram_a", i, sram_a[i], sa_m[i]);
          chk("sram_dout", i, sram_dout[i], sd_m[i]);
          chk("checksum", i, checksum[i], sum_m[i]);

          if (we_n[i] == 1'b0) begin
            run[i]++;
          end else if (prev_we[i] == 1'b0) begin
            chk("we_pulse_len", i, run[i], PW[i]);
            run[i] = 0;
          end
          if (rec && i == 0 && !we_n[0] && prev_we[0]) wr0.push_back({sram_a[0], sram_dout[0]});
          if (rec && i == 1 && busy[1] && (!prev_busy[1] || rom_a[1] != prev_ra1)) seq1.push_back(rom_a[1]);
          if (busy[i] && !prev_busy[i]) t0[i] = cyc;
          if (done[i] && !prev_done[i]) begin
            lat[i] = cyc - t0[i];
            done_rises[i]++;
          end
          prev_we[i] = we_n[i]; prev_busy[i] = busy[i]; prev_done[i] = done[i];
          if (i == 1) prev_ra1 = rom_a[1];
        end
      end
    end
  end

  task automatic pulse_start(input logic [N-1:0] m);
    @(negedge clk);
    #1;
    for (int i = 0; i < N; i++) start[i] = m[i];
    @(negedge clk);
    #1;
    for (int i = 0; i < N; i++) start[i] = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    bit ok = 1'b0;
    while (!ok && n < budget) begin
      @(negedge clk);
      n++;
      ok = 1'b1;
      for (int i = 0; i < N; i++) if (done[i] !== 1'b1) ok = 1'b0;
    end
    #2;
    chk("done_in_budget", 0, 32'(ok), 32'd1);
  endtask

  task automatic clear_rises();
    for (int i = 0; i < N; i++) done_rises[i] = 0;
  endtask

  initial begin
    logic [7:0]  exp_b [4];
    int          exp_s [4];
    logic [15:0] exp_sum0;
    int          n;
    int          rises;
    bit          ok;
    logic        pr;

    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_s = '{16382, 16383, 0, 1};
`ifdef LOADER_CHECKSUM_EN
    exp_sum0 = 16'h00AA;
`else
    exp_sum0 = 16'h0000;
`endif
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      start[i] = 1'b0;
      grant[i] = 1'b1;
    end
    for (int a = 0; a < 16384; a++) rom[a] = 8'($urandom);
    rom[14'h0200] = 8'h11; rom[14'h0201] = 8'h22; rom[14'h0202] = 8'h33; rom[14'h0203] = 8'h44;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    // Basic copy with grant tied high, plus pointer wrap on instance 1.
    clear_rises();
    rec = 1'b1;
    pulse_start(3'b111);
    wait_done(200);
    rec = 1'b0;
    for (int i = 0; i < N; i++) begin
      chk("latency", i, lat[i], LAT[i]);
      chk("done_once", i, done_rises[i], 1);
    end
    chk("checksum_final", 0, checksum[0], exp_sum0);
    chk("model_sum", 0, sum_m[0], exp_sum0);
    chk("write_count", 0, wr0.size(), 4);
    for (int j = 0; j < wr0.size() && j < 4; j++) chk("sram_write", j, wr0[j], {21'(j), exp_b[j]});
    chk("rom_seq_len", 1, seq1.size(), 4);
    for (int j = 0; j < seq1.size() && j < 4; j++) chk("rom_seq", j, seq1[j], exp_s[j]);

    // Five-cycle grant stall in the ARB of the third byte on instance 0.
    pulse_start(3'b111);
    n = 0; rises = 0; pr = req[0];
    while (rises < 3 && n < 100) begin
      @(negedge clk);
      n++;
      if (req[0] && !pr) rises++;
      pr = req[0];
    end
    chk("stall_reached", 0, rises, 3);
    #1 grant[0] = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("stall_we_n", 0, we_n[0], 1'b1);
      chk("stall_req", 0, req[0], 1'b1);
    end
    #1 grant[0] = 1'b1;
    wait_done(200);
    chk("stall_latency", 0, lat[0], LAT[0] + 5);
    chk("nostall_latency", 1, lat[1], LAT[1]);

    // Start pulses while busy are ignored; exactly one done per copy.
    clear_rises();
    pulse_start(3'b111);
    repeat (7) @(negedge clk);
    pulse_start(3'b111);
    wait_done(200);
    for (int i = 0; i < N; i++) chk("single_done", i, done_rises[i], 1);

    // Start in the DONE cycle is dropped, start in the following IDLE cycle is taken.
    pulse_start(3'b001);
    n = 0;
    while (done[0] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reach_done", 0, done[0], 1'b1);
    #1 start[0] = 1'b1;
    @(negedge clk);
    chk("start_in_done_ignored", 0, busy[0], 1'b0);
    @(negedge clk);
    chk("start_after_done_taken", 0, busy[0], 1'b1);
    #1 start[0] = 1'b0;
    wait_done(200);

    // Asynchronous reset during WRITE, then a fresh copy from SRC_BASE.
    pulse_start(3'b111);
    n = 0;
    while (we_n[0] !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reach_write", 0, we_n[0], 1'b0);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      chk("async_busy", i, busy[i], 1'b0);
      chk("async_req", i, req[i], 1'b0);
      chk("async_we_n", i, we_n[i], 1'b1);
    end
    @(negedge clk);
    #1 rst_n = 1'b1;
    pulse_start(3'b111);
    chk("restart_src", 0, rom_a[0], 14'h0200);
    wait_done(200);

    // Randomised grant and start traffic.
    repeat (3000) begin
      @(negedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        grant[i] = ($urandom_range(0, 3) != 0);
        start[i] = ($urandom_range(0, 19) == 0);
      end
    end
    @(negedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      grant[i] = 1'b1;
      start[i] = 1'b0;
    end
    n = 0; ok = 1'b0;
    while (!ok && n < 300) begin
      @(negedge clk);
      n++;
      ok = 1'b1;
      for (int i = 0; i < N; i++) if (busy[i] !== 1'b0) ok = 1'b0;
    end
    #2;
    chk("idle_in_budget", 0, 32'(ok), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
